// File: rtl/load_unit_mo.sv
// Multi-outstanding load unit: translates, issues to the D$ load port, tracks in-flight loads
// by buffer slot and writes back aligned, extended results that may return out of order.
module load_unit_mo #(
  parameter int unsigned NR_LOAD_BUF   = 4,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned VLEN          = 39,
  parameter int unsigned PLEN          = 56,
  parameter int unsigned XLEN          = 64,
  localparam int unsigned IDW          = $clog2(NR_LOAD_BUF),
  localparam int unsigned OFFB         = $clog2(XLEN / 8)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     valid_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  input  logic [VLEN-1:0]          vaddr_i,
  input  logic [2:0]               op_i,
  output logic                     pop_ld_o,
  output logic                     translation_req_o,
  input  logic [PLEN-1:0]          paddr_i,
  input  logic                     dtlb_hit_i,
  input  logic                     nonidem_i,
  input  logic                     page_offset_match_i,
  input  logic                     store_buffer_empty_i,
  input  logic [TRANS_ID_BITS-1:0] commit_trans_id_i,
  output logic                     req_o,
  input  logic                     gnt_i,
  output logic [11:0]              index_o,
  output logic [IDW-1:0]           id_o,
  output logic [1:0]               size_o,
  output logic [PLEN-13:0]         tag_o,
  output logic                     tag_valid_o,
  output logic                     kill_o,
  input  logic                     rvalid_i,
  input  logic [IDW-1:0]           rid_i,
  input  logic [XLEN-1:0]          rdata_i,
  output logic                     valid_o,
  output logic [TRANS_ID_BITS-1:0] trans_id_o,
  output logic [XLEN-1:0]          result_o
);

  localparam logic [2:0] OpLb  = 3'd0;
  localparam logic [2:0] OpLbu = 3'd1;
  localparam logic [2:0] OpLh  = 3'd2;
  localparam logic [2:0] OpLhu = 3'd3;
  localparam logic [2:0] OpLw  = 3'd4;
  localparam logic [2:0] OpLwu = 3'd5;

  typedef enum logic [2:0] {
    StIdle,
    StWaitGnt,
    StWaitTranslation,
    StWaitNi,
    StSendTag
  } state_e;

  state_e state_q;

  logic [NR_LOAD_BUF-1:0]   valid_q, killed_q;
  logic [TRANS_ID_BITS-1:0] tid_q [NR_LOAD_BUF];
  logic [OFFB-1:0]          off_q [NR_LOAD_BUF];
  logic [2:0]               op_q  [NR_LOAD_BUF];

  // Request captured when it cannot be granted immediately
  logic [IDW-1:0]           req_id_q;
  logic [11:0]              req_index_q;
  logic [2:0]               req_op_q;
  logic [TRANS_ID_BITS-1:0] req_tid_q;
  logic [PLEN-13:0]         req_tag_q;
  logic [PLEN-13:0]         tag_q;
  logic                     tag_kill_q;

  logic                     full, empty, ni_ok, issue_ok, accept_st, wait_gnt;
  logic                     req_new, gnt_fire, rsp_hit, rsp_live;
  logic [IDW-1:0]           free_idx, cur_id;
  logic [11:0]              cur_index;
  logic [2:0]               cur_op;
  logic [TRANS_ID_BITS-1:0] cur_tid;
  logic [PLEN-13:0]         cur_tag;
  logic [XLEN-1:0]          shifted, ld_result;
  int                       ext_bits;
  logic                     sign_ext, sign_bit;
  logic                     unused_addr_bits;

  assign unused_addr_bits = ^{vaddr_i[VLEN-1:12], paddr_i[11:0]};

  function automatic logic [1:0] op_size(input logic [2:0] op);
    case (op)
      OpLb, OpLbu: op_size = 2'd0;
      OpLh, OpLhu: op_size = 2'd1;
      OpLw, OpLwu: op_size = 2'd2;
      default:     op_size = 2'd3;
    endcase
  endfunction

  always_comb begin
    free_idx = '0;
    for (int i = int'(NR_LOAD_BUF) - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDW'(i);
    end
  end

  assign full      = &valid_q;
  assign empty     = ~|valid_q;
  assign ni_ok     = !nonidem_i ||
                     (store_buffer_empty_i && empty && (commit_trans_id_i == trans_id_i));
  assign issue_ok  = valid_i && dtlb_hit_i && !page_offset_match_i && !full && ni_ok;
  assign wait_gnt  = (state_q == StWaitGnt);
  assign accept_st = (state_q == StIdle) || (state_q == StWaitTranslation) ||
                     (state_q == StWaitNi) || (state_q == StSendTag);
  assign req_new   = accept_st && issue_ok && !flush_i;
  assign gnt_fire  = req_o && gnt_i;

  assign cur_id    = wait_gnt ? req_id_q    : free_idx;
  assign cur_index = wait_gnt ? req_index_q : vaddr_i[11:0];
  assign cur_op    = wait_gnt ? req_op_q    : op_i;
  assign cur_tid   = wait_gnt ? req_tid_q   : trans_id_i;
  assign cur_tag   = wait_gnt ? req_tag_q   : paddr_i[PLEN-1:12];

  assign req_o             = req_new || wait_gnt;
  assign pop_ld_o          = gnt_fire && !flush_i;
  assign translation_req_o = valid_i && ((state_q == StIdle) || (state_q == StWaitTranslation));
  assign index_o           = req_o ? cur_index : '0;
  assign id_o              = req_o ? cur_id : '0;
  assign size_o            = req_o ? op_size(cur_op) : '0;
  assign tag_o             = tag_q;
  assign tag_valid_o       = (state_q == StSendTag) && !flush_i && !tag_kill_q;
  assign kill_o            = (state_q == StSendTag) && (flush_i || tag_kill_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      tag_q       <= '0;
      tag_kill_q  <= 1'b0;
      req_id_q    <= '0;
      req_index_q <= '0;
      req_op_q    <= '0;
      req_tid_q   <= '0;
      req_tag_q   <= '0;
    end else begin
      // A grant that coincides with a flush still owes the D$ a kill in the tag phase
      tag_kill_q <= gnt_fire && flush_i;
      if (gnt_fire) tag_q <= cur_tag;
      if (req_new) begin
        req_id_q    <= free_idx;
        req_index_q <= vaddr_i[11:0];
        req_op_q    <= op_i;
        req_tid_q   <= trans_id_i;
        req_tag_q   <= paddr_i[PLEN-1:12];
      end
      if (flush_i) begin
        state_q <= (wait_gnt && gnt_i) ? StSendTag : StIdle;
      end else if (wait_gnt) begin
        if (gnt_i) state_q <= StSendTag;
      end else if (!valid_i) begin
        state_q <= StIdle;
      end else if (!dtlb_hit_i) begin
        state_q <= StWaitTranslation;
      end else if (!issue_ok) begin
        state_q <= StWaitNi;
      end else begin
        state_q <= gnt_i ? StSendTag : StWaitGnt;
      end
    end
  end

  assign rsp_hit  = rvalid_i && valid_q[rid_i];
  assign rsp_live = rsp_hit && !killed_q[rid_i] && !flush_i;
  assign shifted  = rdata_i >> {off_q[rid_i], 3'b000};

  always_comb begin
    ext_bits = int'(XLEN);
    sign_ext = 1'b0;
    sign_bit = 1'b0;
    case (op_q[rid_i])
      OpLb:    begin ext_bits = 8;  sign_ext = 1'b1; sign_bit = shifted[7];  end
      OpLbu:   ext_bits = 8;
      OpLh:    begin ext_bits = 16; sign_ext = 1'b1; sign_bit = shifted[15]; end
      OpLhu:   ext_bits = 16;
      OpLw:    begin ext_bits = 32; sign_ext = 1'b1; sign_bit = shifted[31]; end
      OpLwu:   ext_bits = 32;
      default: ext_bits = int'(XLEN);
    endcase
    for (int i = 0; i < int'(XLEN); i++) begin
      ld_result[i] = (i < ext_bits) ? shifted[i] : (sign_ext && sign_bit);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= '0;
      killed_q <= '0;
      for (int i = 0; i < int'(NR_LOAD_BUF); i++) begin
        tid_q[i] <= '0;
        off_q[i] <= '0;
        op_q[i]  <= '0;
      end
    end else begin
      if (flush_i) killed_q <= killed_q | valid_q;
      if (rsp_hit) begin
        valid_q[rid_i]  <= 1'b0;
        killed_q[rid_i] <= 1'b0;
      end
      // Allocated slot is free in valid_q, so it never collides with a live response
      if (gnt_fire) begin
        valid_q[cur_id]  <= 1'b1;
        killed_q[cur_id] <= flush_i;
        tid_q[cur_id]    <= cur_tid;
        off_q[cur_id]    <= cur_index[OFFB-1:0];
        op_q[cur_id]     <= cur_op;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o    <= 1'b0;
      trans_id_o <= '0;
      result_o   <= '0;
    end else begin
      valid_o <= rsp_live;
      if (rsp_live) begin
        trans_id_o <= tid_q[rid_i];
        result_o   <= ld_result;
      end
    end
  end

endmodule

// File: tb/tb_load_unit_mo.sv
// Directed bench for load_unit_mo: issue, extension, full buffer, out-of-order return,
// non-idempotent gating, wait-for-grant and flush.
module tb_load_unit_mo;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i, valid_i, dtlb_hit_i, nonidem_i, page_offset_match_i;
  logic        store_buffer_empty_i, gnt_i, rvalid_i;
  logic [2:0]  trans_id_i, commit_trans_id_i, op_i, trans_id_o;
  logic [38:0] vaddr_i;
  logic [55:0] paddr_i;
  logic [1:0]  rid_i, id_o, size_o;
  logic [63:0] rdata_i, result_o;
  logic        pop_ld_o, translation_req_o, req_o, tag_valid_o, kill_o, valid_o;
  logic [11:0] index_o;
  logic [43:0] tag_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  load_unit_mo dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i),
    .trans_id_i(trans_id_i), .vaddr_i(vaddr_i), .op_i(op_i), .pop_ld_o(pop_ld_o),
    .translation_req_o(translation_req_o), .paddr_i(paddr_i), .dtlb_hit_i(dtlb_hit_i),
    .nonidem_i(nonidem_i), .page_offset_match_i(page_offset_match_i),
    .store_buffer_empty_i(store_buffer_empty_i), .commit_trans_id_i(commit_trans_id_i),
    .req_o(req_o), .gnt_i(gnt_i), .index_o(index_o), .id_o(id_o), .size_o(size_o),
    .tag_o(tag_o), .tag_valid_o(tag_valid_o), .kill_o(kill_o), .rvalid_i(rvalid_i),
    .rid_i(rid_i), .rdata_i(rdata_i), .valid_o(valid_o), .trans_id_o(trans_id_o),
    .result_o(result_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Request cycle with same-cycle grant, then returns in the tag cycle
  task automatic issue(input logic [2:0] tid, input logic [38:0] va, input logic [2:0] op,
                       input logic [55:0] pa, input logic [1:0] exp_id);
    valid_i = 1'b1; dtlb_hit_i = 1'b1; gnt_i = 1'b1;
    trans_id_i = tid; vaddr_i = va; op_i = op; paddr_i = pa;
    #1;
    check_eq("issue_req", req_o, 1'b1);
    check_eq("issue_pop", pop_ld_o, 1'b1);
    check_eq("issue_id", id_o, exp_id);
    tick();
    valid_i = 1'b0; gnt_i = 1'b0;
    #1;
    check_eq("issue_tag_valid", tag_valid_o, 1'b1);
    check_eq("issue_tag", tag_o, pa[55:12]);
  endtask

  task automatic respond(input logic [1:0] rid, input logic [63:0] data, input logic exp_v,
                         input logic [2:0] exp_tid, input logic [63:0] exp_res);
    rvalid_i = 1'b1; rid_i = rid; rdata_i = data;
    tick();
    rvalid_i = 1'b0;
    #1;
    check_eq("rsp_valid", valid_o, exp_v);
    if (exp_v) begin
      check_eq("rsp_tid", trans_id_o, exp_tid);
      check_eq("rsp_result", result_o, exp_res);
    end
  endtask

  task automatic run_ext(input logic [2:0] op, input logic [2:0] off, input logic [63:0] data,
                         input logic [63:0] exp);
    issue(3'd2, {36'h0, off}, op, 56'h0000_4000_0000, 2'd0);
    respond(2'd0, data, 1'b1, 3'd2, exp);
  endtask

  initial begin
    rst_ni = 1'b0;
    flush_i = 0; valid_i = 0; dtlb_hit_i = 0; nonidem_i = 0; page_offset_match_i = 0;
    store_buffer_empty_i = 1; gnt_i = 0; rvalid_i = 0; trans_id_i = 0;
    commit_trans_id_i = 0; op_i = 0; vaddr_i = 0; paddr_i = 0; rid_i = 0; rdata_i = 0;
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("rst_valid_o", valid_o, 1'b0);
    check_eq("rst_req_o", req_o, 1'b0);
    check_eq("rst_tag_valid", tag_valid_o, 1'b0);
    check_eq("rst_kill", kill_o, 1'b0);
    check_eq("rst_result", result_o, 64'h0);
    rst_ni = 1'b1;
    tick();

    // LD, best-case latency
    valid_i = 1; dtlb_hit_i = 1; gnt_i = 1; trans_id_i = 3'd1; vaddr_i = 39'h10;
    op_i = 3'd6; paddr_i = 56'h8000_0010;
    #1;
    check_eq("ld_size", size_o, 2'd3);
    check_eq("ld_index", index_o, 12'h010);
    check_eq("ld_treq", translation_req_o, 1'b1);
    #1;
    issue(3'd1, 39'h10, 3'd6, 56'h8000_0010, 2'd0);
    tick();
    tick();
    respond(2'd0, 64'h1122_3344_5566_7788, 1'b1, 3'd1, 64'h1122_3344_5566_7788);
    tick();
    check_eq("ld_valid_drop", valid_o, 1'b0);

    // Alignment and extension
    run_ext(3'd0, 3'd7, 64'h80AB_CDEF_0123_4567, 64'hFFFF_FFFF_FFFF_FF80);
    run_ext(3'd1, 3'd7, 64'h80AB_CDEF_0123_4567, 64'h0000_0000_0000_0080);
    run_ext(3'd2, 3'd6, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001);
    run_ext(3'd3, 3'd6, 64'h8001_0000_0000_0000, 64'h0000_0000_0000_8001);
    run_ext(3'd4, 3'd4, 64'h7654_3210_DEAD_BEEF, 64'h0000_0000_7654_3210);
    run_ext(3'd5, 3'd0, 64'h0000_0000_F000_0001, 64'h0000_0000_F000_0001);
    run_ext(3'd4, 3'd0, 64'h0000_0000_F000_0001, 64'hFFFF_FFFF_F000_0001);
    run_ext(3'd0, 3'd1, 64'h0000_0000_0000_7F00, 64'h0000_0000_0000_007F);
    tick();

    // Fill the buffer, overlapping each request with the previous tag phase
    for (int i = 0; i < 4; i++) begin
      issue(3'(i), 39'h100, 3'd6, 56'h9000_0100, 2'(i));
    end
    valid_i = 1; dtlb_hit_i = 1; gnt_i = 1; trans_id_i = 3'd4; op_i = 3'd6;
    vaddr_i = 39'h200; paddr_i = 56'h9000_0200;
    #1;
    check_eq("full_req", req_o, 1'b0);
    check_eq("full_pop", pop_ld_o, 1'b0);
    tick();
    rvalid_i = 1; rid_i = 2'd2; rdata_i = 64'hAAAA_0000_0000_0002;
    #1;
    check_eq("free_same_cycle_req", req_o, 1'b0);
    tick();
    rvalid_i = 0;
    #1;
    check_eq("realloc_req", req_o, 1'b1);
    check_eq("realloc_pop", pop_ld_o, 1'b1);
    check_eq("realloc_id", id_o, 2'd2);
    check_eq("rid2_valid", valid_o, 1'b1);
    check_eq("rid2_tid", trans_id_o, 3'd2);
    check_eq("rid2_result", result_o, 64'hAAAA_0000_0000_0002);
    tick();
    valid_i = 0; gnt_i = 0;
    tick();

    // Out-of-order return
    respond(2'd3, 64'h3333, 1'b1, 3'd3, 64'h3333);
    respond(2'd1, 64'h1111, 1'b1, 3'd1, 64'h1111);
    respond(2'd0, 64'h0000_0000_0000_0BAD, 1'b1, 3'd0, 64'h0BAD);
    respond(2'd2, 64'h4444, 1'b1, 3'd4, 64'h4444);
    tick();

    // Non-idempotent gating
    valid_i = 1; dtlb_hit_i = 1; gnt_i = 1; nonidem_i = 1; store_buffer_empty_i = 0;
    trans_id_i = 3'd5; commit_trans_id_i = 3'd5; op_i = 3'd6;
    vaddr_i = 39'h18; paddr_i = 56'hA000_0018;
    #1;
    check_eq("ni_sb_busy_req", req_o, 1'b0);
    tick();
    check_eq("ni_wait_pop", pop_ld_o, 1'b0);
    store_buffer_empty_i = 1; commit_trans_id_i = 3'd4;
    #1;
    check_eq("ni_commit_miss_req", req_o, 1'b0);
    commit_trans_id_i = 3'd5;
    #1;
    check_eq("ni_issue_req", req_o, 1'b1);
    check_eq("ni_issue_pop", pop_ld_o, 1'b1);
    tick();
    valid_i = 0; gnt_i = 0; nonidem_i = 0;
    #1;
    check_eq("ni_tag_valid", tag_valid_o, 1'b1);
    respond(2'd0, 64'h5555, 1'b1, 3'd5, 64'h5555);
    tick();

    // Flush during tag phase
    issue(3'd6, 39'h20, 3'd6, 56'hB000_0020, 2'd0);
    flush_i = 1;
    #1;
    check_eq("flush_kill", kill_o, 1'b1);
    check_eq("flush_tag_valid", tag_valid_o, 1'b0);
    tick();
    flush_i = 0;
    tick();
    respond(2'd0, 64'hDEAD, 1'b0, 3'd0, 64'h0);

    // Waiting for grant holds the request; then same-cycle alloc and response
    valid_i = 1; dtlb_hit_i = 1; gnt_i = 0; trans_id_i = 3'd7; op_i = 3'd4;
    vaddr_i = 39'h234; paddr_i = 56'h1234_5234;
    #1;
    check_eq("wg_req", req_o, 1'b1);
    check_eq("wg_pop", pop_ld_o, 1'b0);
    tick();
    vaddr_i = 39'hFFF; paddr_i = 56'h0;
    #1;
    check_eq("wg_hold_req", req_o, 1'b1);
    check_eq("wg_hold_index", index_o, 12'h234);
    gnt_i = 1;
    #1;
    check_eq("wg_gnt_pop", pop_ld_o, 1'b1);
    tick();
    valid_i = 0; gnt_i = 0;
    #1;
    check_eq("wg_tag", tag_o, 44'h12345);
    valid_i = 1; gnt_i = 1; trans_id_i = 3'd6; op_i = 3'd6; vaddr_i = 39'h8;
    paddr_i = 56'hC000_0008;
    rvalid_i = 1; rid_i = 2'd0; rdata_i = 64'hFFFF_FFFE_0000_0000;
    #1;
    check_eq("both_id", id_o, 2'd1);
    tick();
    valid_i = 0; gnt_i = 0; rvalid_i = 0;
    #1;
    check_eq("both_rsp_tid", trans_id_o, 3'd7);
    check_eq("both_rsp_result", result_o, 64'hFFFF_FFFF_FFFF_FFFE);
    respond(2'd1, 64'h6666, 1'b1, 3'd6, 64'h6666);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
